fp_add_pipe: RTL
================

Name: fp_add_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 floating-point adder/subtractor; successor to the combinational truncating adder wrapped in a fixed delay line.
- Adds round-to-nearest-even, inf/NaN handling, a per-operation add/sub select and a tag that passes through with each operation.
- Uses valid/ready stream handshakes with full backpressure.
- Drop-in for accumulation and reduction paths in the MXU.

Parameters:
- EXP_W, 8: exponent width; BIAS = 2^(EXP_W-1)-1.
- MANT_W, 23: stored mantissa width. Supported: 23 (fp32), 10 (fp16), 7 (bf16).
- TAG_W, 8: width of the user tag carried alongside each operation.
- Derived: FLOAT_W = 1+EXP_W+MANT_W.

Ports:
- aclk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- s_axis_tvalid, in, 1: operand pair valid.
- s_axis_tready, out, 1: block can accept an operand pair.
- s_axis_a_tdata, in, FLOAT_W: operand A as {sign, exp, mant}.
- s_axis_b_tdata, in, FLOAT_W: operand B.
- s_axis_op, in, 1: 0 = A+B, 1 = A-B (B sign inverted before all processing).
- s_axis_tuser, in, TAG_W: tag, returned unchanged with the result.
- m_axis_result_tvalid, out, 1: result valid.
- m_axis_result_tready, in, 1: downstream accepts the result.
- m_axis_result_tdata, out, FLOAT_W: rounded sum.
- m_axis_result_tuser, out, TAG_W: tag of this result.

Behaviour:
- Reset
  - All stage valid bits clear; m_axis_result_tvalid=0, m_axis_result_tdata=0, m_axis_result_tuser=0.
  - s_axis_tready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; no partial output is produced.
- Handshake
  - adv = !m_axis_result_tvalid | m_axis_result_tready, and s_axis_tready = adv.
  - This is a combinational path from m_axis_result_tready to s_axis_tready; the path is accepted.
  - An operand pair is accepted when s_axis_tvalid & s_axis_tready.
  - All three stages shift together when adv=1 and hold when adv=0.
  - Output data, user and valid stay stable while tvalid=1 & tready=0.
- Latency and ordering
  - Exactly 3 cycles from acceptance to m_axis_result_tvalid when there is no stall.
  - Throughput is 1 operation per cycle.
  - Results are returned in acceptance order.
- Stage 1 (unpack/align)
  - Decode fields; exp=0 means subnormal, with hidden bit 0 and effective exponent 1-BIAS.
  - Detect special cases: exp all ones means inf (mant=0) or NaN.
  - Swap operands so the larger magnitude is first (exponent, then fraction).
  - Shift the smaller operand right by the exponent difference into a MANT_W+4-bit field {hidden, mant, guard, round, sticky}. Sticky is the OR of all bits shifted past round; a difference ≥ MANT_W+3 leaves only sticky.
- Stage 2 (add)
  - Effective subtract = sign_a XOR sign_b_eff. Add or subtract magnitudes with one carry bit.
  - Result sign = sign of the larger operand.
  - Leading-zero count on the sum.
- Stage 3 (normalise/round/pack)
  - On carry-out: shift right 1 and exponent+1, with the dropped bit folded into sticky.
  - Otherwise shift left by lzc, limited so the exponent does not go below 1-BIAS; an exponent clamped at 1-BIAS gives a subnormal output (biased exp=0).
  - Round to nearest, ties to even: increment when G & (R|S|LSB).
  - A rounding carry renormalises: exponent+1, and a subnormal can become the minimum normal.
  - A biased exponent ≥ 2^EXP_W-1 after rounding outputs ±inf.
- Special cases (take priority over the arithmetic)
  - Any NaN input, or inf + (-inf) after op is applied, outputs the canonical qNaN {0, all ones, 1, 0...}.
  - A single inf outputs that inf with its effective sign.
- Zero results
  - An exact zero from opposite-sign operands is +0.
  - (-0)+(-0) is -0; (+0)+(-0) is +0.

Test Plan:
- Basic add then subtract: 0x3F800000+0x40000000 op=0 → 0x40400000; 0x40400000-0x40400000 op=1 → 0x00000000. Each result tvalid exactly 3 cycles after acceptance, tuser echoed (0x5A, 0xA5).
- RNE tie: 0x3F800001+0x33800000 → 0x3F800002 (truncation would give 0x3F800001). 0x3F800000+0x33800000 → 0x3F800000 (tie to even).
- Overflow and special cases: 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000; 0x7F800000+0xFF800000 → 0x7FC00000; 0x7FC00001+0x3F800000 → 0x7FC00000; 0x80000000+0x80000000 → 0x80000000.
- Subnormals: 0x00000001+0x00000001 → 0x00000002; 0x00800000-0x00000001 op=1 → 0x007FFFFF; 0x007FFFFF+0x00000001 → 0x00800000.
- Backpressure: issue 6 back-to-back ops with tags 0..5; drop m_axis_result_tready for 5 cycles after the first valid.
  - Output holds stable and s_axis_tready=0 while stalled.
  - After release all 6 results arrive in order, tags 0..5, none lost or duplicated.
  - Scoreboard against a reference model.
- Reset mid-stream: assert reset for 1 cycle with 3 ops in flight.
  - Next cycle m_axis_result_tvalid=0 and outputs are 0; none of the 3 ops ever appears.
  - An op accepted after reset returns its correct result 3 cycles after acceptance.
  - Repeat the full suite with MANT_W=7, EXP_W=8 (bf16): 0x3F80+0x4000 → 0x4040.

Source files
------------

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 3-stage pipelined IEEE-754 adder/subtractor with round-to-nearest-even
//
// Purpose: adds (op=0) or subtracts (op=1) two IEEE-754 operands in three
// register stages (unpack/align, add, normalise/round/pack). All stages
// advance together; the output holds while downstream stalls. A user tag
// travels with every operation.
//
// Ports:
//   aclk, reset             clock, synchronous active-high reset
//   s_axis_tvalid/tready    operand-pair handshake
//   s_axis_a_tdata/b_tdata  operands {sign, exp, mant}
//   s_axis_op               0 = A+B, 1 = A-B
//   s_axis_tuser            tag returned with the result
//   m_axis_result_tvalid/tready  result handshake
//   m_axis_result_tdata     rounded result
//   m_axis_result_tuser     tag of this result
module fp_add_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int TAG_W  = 8,
  localparam int FLOAT_W = 1 + EXP_W + MANT_W
) (
  input  logic               aclk,
  input  logic               reset,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [FLOAT_W-1:0] s_axis_a_tdata,
  input  logic [FLOAT_W-1:0] s_axis_b_tdata,
  input  logic               s_axis_op,
  input  logic [TAG_W-1:0]   s_axis_tuser,
  output logic               m_axis_result_tvalid,
  input  logic               m_axis_result_tready,
  output logic [FLOAT_W-1:0] m_axis_result_tdata,
  output logic [TAG_W-1:0]   m_axis_result_tuser
);

  localparam int W    = MANT_W + 4;   // {hidden, mant, guard, round, sticky}
  localparam int LZ_W = $clog2(W + 1);
  localparam int XW   = EXP_W + 2;    // exponent headroom for carry and rounding
  localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
  localparam logic [MANT_W-1:0] QNAN_MANT = MANT_W'(1) << (MANT_W - 1);

  logic adv;
  assign adv           = !m_axis_result_tvalid || m_axis_result_tready;
  assign s_axis_tready = adv;

  function automatic logic [LZ_W-1:0] count_lz(input logic [W-1:0] v);
    count_lz = LZ_W'(W);
    for (int i = 0; i < W; i++)
      if (v[i]) count_lz = LZ_W'(W - 1 - i);
  endfunction

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic              sa, sb, a_big;
  logic [EXP_W-1:0]  ea, eb, big_e, small_e, diff;
  logic [MANT_W-1:0] ma, mb;
  logic              nan_a, nan_b, inf_a, inf_b;
  logic [W-1:0]      big_m, small_m, small_sh, sh_mask;
  logic              sp_nan, sp_inf, sp_sign;

  always_comb begin
    {sa, ea, ma} = s_axis_a_tdata;
    {sb, eb, mb} = s_axis_b_tdata;
    sb       = sb ^ s_axis_op;
    nan_a    = (ea == EXP_MAX) && (ma != '0);
    nan_b    = (eb == EXP_MAX) && (mb != '0);
    inf_a    = (ea == EXP_MAX) && (ma == '0);
    inf_b    = (eb == EXP_MAX) && (mb == '0);
    sp_nan   = nan_a || nan_b || (inf_a && inf_b && (sa != sb));
    sp_inf   = inf_a || inf_b;
    sp_sign  = inf_a ? sa : sb;
    // raw {exp, mant} ordering equals magnitude ordering, subnormals included
    a_big    = {ea, ma} >= {eb, mb};
    big_e    = a_big ? ea : eb;
    small_e  = a_big ? eb : ea;
    big_m    = a_big ? {ea != '0, ma, 3'b000} : {eb != '0, mb, 3'b000};
    small_m  = a_big ? {eb != '0, mb, 3'b000} : {ea != '0, ma, 3'b000};
    // subnormals live at the exponent of the smallest normal
    if (big_e == '0)   big_e   = EXP_W'(1);
    if (small_e == '0) small_e = EXP_W'(1);
    diff     = big_e - small_e;
    sh_mask  = ~({W{1'b1}} << diff);
    small_sh = (small_m >> diff) | {{(W-1){1'b0}}, |(small_m & sh_mask)};
  end

  logic              v1, s1_sign, s1_sub, s1_nan, s1_inf, s1_isign;
  logic [EXP_W-1:0]  s1_exp;
  logic [W-1:0]      s1_big, s1_small;
  logic [TAG_W-1:0]  s1_tag;

  // ---------------- stage 2: add/subtract magnitudes, count zeros --------
  logic [W:0]        sum2;
  logic [LZ_W-1:0]   lz2;
  logic              sign2;

  always_comb begin
    sum2  = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                   : ({1'b0, s1_big} + {1'b0, s1_small});
    lz2   = count_lz(sum2[W-1:0]);
    // exact cancellation yields +0; like-signed zeros keep their sign
    sign2 = (s1_sub && (sum2 == '0)) ? 1'b0 : s1_sign;
  end

  logic              v2, s2_sign, s2_nan, s2_inf, s2_isign;
  logic [EXP_W-1:0]  s2_exp;
  logic [W:0]        s2_sum;
  logic [LZ_W-1:0]   s2_lz;
  logic [TAG_W-1:0]  s2_tag;

  // ---------------- stage 3: normalise, round, pack ----------------------
  logic [XW-1:0]       e3, lim3, sh3, ef3;
  logic [W-1:0]        m3;
  logic                inc3;
  logic [MANT_W+1:0]   r3;
  logic [MANT_W-1:0]   mant3;
  logic [FLOAT_W-1:0]  res3;

  always_comb begin
    e3   = XW'(s2_exp);
    lim3 = e3 - XW'(1);
    sh3  = '0;
    if (s2_sum[W]) begin
      m3 = {s2_sum[W:2], s2_sum[1] | s2_sum[0]};
      e3 = e3 + XW'(1);
    end else begin
      // never normalise below the minimum exponent; what remains is subnormal
      sh3 = (XW'(s2_lz) < lim3) ? XW'(s2_lz) : lim3;
      m3  = s2_sum[W-1:0] << sh3;
      e3  = e3 - sh3;
    end
    inc3 = m3[2] && (m3[1] || m3[0] || m3[3]);
    r3   = {1'b0, m3[W-1:3]} + (MANT_W+2)'(inc3);
    if (r3[MANT_W+1]) begin
      ef3   = e3 + XW'(1);
      mant3 = r3[MANT_W:1];
    end else begin
      // hidden bit clear means subnormal/zero; rounding into it gives min normal
      ef3   = r3[MANT_W] ? e3 : '0;
      mant3 = r3[MANT_W-1:0];
    end
    if (s2_nan)
      res3 = {1'b0, EXP_MAX, QNAN_MANT};
    else if (s2_inf)
      res3 = {s2_isign, EXP_MAX, {MANT_W{1'b0}}};
    else if (ef3 >= XW'(EXP_MAX))
      res3 = {s2_sign, EXP_MAX, {MANT_W{1'b0}}};
    else
      res3 = {s2_sign, ef3[EXP_W-1:0], mant3};
  end

  // ---------------- pipeline registers -----------------------------------
  always_ff @(posedge aclk) begin
    if (reset) begin
      v1                   <= 1'b0;
      v2                   <= 1'b0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      m_axis_result_tuser  <= '0;
    end else if (adv) begin
      v1                   <= s_axis_tvalid;
      v2                   <= v1;
      m_axis_result_tvalid <= v2;
      m_axis_result_tdata  <= res3;
      m_axis_result_tuser  <= s2_tag;
    end
  end

  always_ff @(posedge aclk) begin
    if (adv) begin
      s1_sign  <= a_big ? sa : sb;
      s1_sub   <= sa ^ sb;
      s1_exp   <= big_e;
      s1_big   <= big_m;
      s1_small <= small_sh;
      s1_nan   <= sp_nan;
      s1_inf   <= sp_inf;
      s1_isign <= sp_sign;
      s1_tag   <= s_axis_tuser;
      s2_sign  <= sign2;
      s2_exp   <= s1_exp;
      s2_sum   <= sum2;
      s2_lz    <= lz2;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_isign <= s1_isign;
      s2_tag   <= s1_tag;
    end
  end

endmodule
